pim_perf_counter_bank: RTL
==========================

Name: pim_perf_counter_bank

Overview:
Synthesizable, multi-core successor to the simulation-only PIM performance monitor. It counts per-core active and skipped (sparsity-gated) packets. It accumulates fixed-point PIM and off-chip-baseline energy in integer pJ and runs windowed activity sampling with a hysteretic hot flag that stands in for the thermal model. Counters are frozen into a shadow bank via a req/ack handshake and read back through an indexed, registered mux. It sits beside the PIM cores and snoops their per-cycle packet strobes.

Parameters:
NUM_CORES, 4, number of monitored PIM cores (1..16)
CNT_W, 32, width of per-core packet counters and cycle counter
EN_W, 48, width of energy accumulators and rd_data
E_ACT_PKT, 2400, pJ per active packet (16 words x (100+50) pJ)
E_IDLE_PKT, 80, pJ per skipped packet (16 words x 5 pJ)
E_BASE_PKT, 49600, pJ per packet on baseline (16 words x 3100 pJ)
WINDOW_LEN, 1024, sample window length in RUN cycles (power of two, >=2)
HOT_THRESH, 3000, window active count above which hot sets
COOL_THRESH, 1000, window active count below which hot clears (< HOT_THRESH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = count
clear  in  1  sync pulse; zero live counters, window, flags
core_active  in  NUM_CORES  per-core strobe: packet computed this cycle
core_skip  in  NUM_CORES  per-core strobe: packet skipped this cycle
snap_req  in  1  request shadow capture
snap_valid  out  1  shadow bank holds a fresh snapshot
snap_ack  in  1  consumer done with snapshot
rd_sel  in  8  read index into shadow bank
rd_data  out  EN_W  registered shadow read data
win_valid  out  1  one-cycle pulse at window end
win_act  out  clog2(WINDOW_LEN*NUM_CORES+1)  active packets in completed window
hot  out  1  hysteretic activity alarm
sat_flag  out  1  sticky: any counter/accumulator saturated
conflict_flag  out  1  sticky: active and skip asserted on the same core and cycle

Behaviour:
- Reset (async, rst_n=0): all counters, accumulators, shadows, rd_data, win_act = 0; snap_valid, win_valid, hot, sat_flag, conflict_flag = 0; FSM = IDLE. Reset mid-snapshot drops snap_valid.
- FSM: IDLE -> RUN when enable=1. RUN -> IDLE when enable=0: live counts are held, the window counter returns to 0, and the partial window is discarded with no win_valid.
- Strobes are sampled only in RUN. In IDLE they are ignored.
- Per core, per RUN cycle:
  - active=1: act_cnt[i]+1.
  - skip=1 and active=0: skip_cnt[i]+1.
  - Both=1: counted as active only, and conflict_flag sets.
- n_act = popcount(effective active); n_skip = popcount(effective skip).
- pim_energy += n_act*E_ACT_PKT + n_skip*E_IDLE_PKT.
- base_energy += (n_act+n_skip)*E_BASE_PKT.
- cycle_cnt += 1 every RUN cycle.
- All updates are visible the following cycle.
- Saturation: every counter and accumulator clamps at all-ones and never wraps. The first clamp sets sat_flag.
- Window: win_cnt runs 0..WINDOW_LEN-1 in RUN and win_acc accumulates n_act. In the cycle win_cnt==WINDOW_LEN-1:
  - The next cycle has win_valid=1 and win_act = win_acc including that last cycle's n_act.
  - win_acc restarts from 0.
  - hot sets if win_act>HOT_THRESH and clears if win_act<COOL_THRESH; otherwise it holds.
- clear: next cycle, live counters, accumulators, window, hot, sat_flag and conflict_flag are 0. The FSM state, shadow bank and snap_valid are unaffected. Strobes coincident with clear are dropped. clear wins over a window-end event.
- Snapshot:
  - snap_req while snap_valid=0: the next cycle the shadow holds the live values including the current cycle's update, and snap_valid=1.
  - snap_req while snap_valid=1 is ignored.
  - snap_ack clears snap_valid the next cycle.
  - snap_req and snap_ack in the same cycle while valid: ack is applied and req is ignored.
- Read map (1-cycle latency, zero-extended to EN_W): 0..N-1 act_cnt[i]; N..2N-1 skip_cnt[i]; 2N pim_energy; 2N+1 base_energy; 2N+2 cycle_cnt; 2N+3 {sat_flag, conflict_flag, hot} in bits [2:0]; any other index returns 0.
- Arithmetic: per-cycle increments use widths sized for NUM_CORES*E_BASE_PKT. Additions compare against the max value before commit.

Decomposition:
- Package pim_perf_pkg: FSM state enum (IDLE, RUN), read-map index offsets as functions of NUM_CORES, default energy constants, and a saturating-add function.
- One sub-module, pim_perf_sat_acc: parametrised saturating accumulator (width, increment width, clear, enable, sat pulse). It is instantiated for each counter and each energy accumulator.
- Popcount and window logic live in the top.

Test Plan:
- Defaults, enable=1, core_active=4'b0011 for 10 cycles, then core_skip=4'b0100 for 5 cycles, then snap_req -> act_cnt0=act_cnt1=10, skip_cnt2=5, pim_energy=48400, base_energy=1240000, cycle_cnt>=15; snap_valid=1 until snap_ack.
- WINDOW_LEN=16, HOT_THRESH=40, COOL_THRESH=8: all 4 cores active for 16 cycles -> win_valid pulse with win_act=64 and hot=1. Next 16 idle cycles -> win_act=0 and hot=0. Then 5 active cycles on 4 cores (win_act=20) -> hot holds its previous value.
- CNT_W=4: core 0 active for 20 cycles -> act_cnt0=15 and sat_flag=1; with other cores idle, act_cnt1..3=0.
- core_active=core_skip=4'b0001 for 3 cycles -> act_cnt0=3, skip_cnt0=0, conflict_flag=1, pim_energy=7200.
- Snapshot taken, then 5 more active cycles on core 0, rd_sel=0 -> rd_data equals the snapshot value, not the live value. snap_req while valid -> shadow unchanged.
- rst_n low for 1 cycle mid-window with snap_valid=1 -> all outputs 0, FSM=IDLE. After enable, the first win_valid arrives exactly WINDOW_LEN RUN cycles later.

Source files
------------

// File: rtl/pim_perf_pkg.sv
// Shared types, read-map layout and saturating arithmetic for the PIM performance counter bank.
package pim_perf_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int unsigned E_ACT_PKT_DEF  = 2400;
  localparam int unsigned E_IDLE_PKT_DEF = 80;
  localparam int unsigned E_BASE_PKT_DEF = 49600;

  // Read-map layout: act_cnt[0..n-1] at 0, then skip_cnt, energies, cycles, flags.
  function automatic int unsigned idx_skip(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned idx_pim(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned idx_base(input int unsigned n);
    return 2 * n + 1;
  endfunction

  function automatic int unsigned idx_cyc(input int unsigned n);
    return 2 * n + 2;
  endfunction

  function automatic int unsigned idx_flags(input int unsigned n);
    return 2 * n + 3;
  endfunction

  // Returns {clamped, result}; result is capped at max instead of wrapping.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) return {1'b1, max};
    return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/pim_perf_sat_acc.sv
// Saturating accumulator; exposes the next-state value so a snapshot can include this cycle's update.
module pim_perf_sat_acc
  import pim_perf_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     nxt,
  output logic             sat
);

  localparam logic [63:0] MAX_V = 64'({W{1'b1}});

  logic [W-1:0] val;
  logic [64:0]  sum;
  logic         unused_hi;

  assign sum       = sat_add(64'(val), 64'(inc), MAX_V);
  assign unused_hi = ^sum[63:W];

  always_comb begin
    nxt = val;
    sat = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (en) begin
      nxt = sum[W-1:0];
      sat = sum[64];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) val <= '0;
    else        val <= nxt;

endmodule

// File: rtl/pim_perf_counter_bank.sv
// Per-core packet/energy counters with windowed hot alarm, shadow snapshot bank and registered readback.
module pim_perf_counter_bank
  import pim_perf_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned EN_W        = 48,
  parameter int unsigned E_ACT_PKT   = E_ACT_PKT_DEF,
  parameter int unsigned E_IDLE_PKT  = E_IDLE_PKT_DEF,
  parameter int unsigned E_BASE_PKT  = E_BASE_PKT_DEF,
  parameter int unsigned WINDOW_LEN  = 1024,
  parameter int unsigned HOT_THRESH  = 3000,
  parameter int unsigned COOL_THRESH = 1000
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         enable,
  input  logic                                         clear,
  input  logic [NUM_CORES-1:0]                         core_active,
  input  logic [NUM_CORES-1:0]                         core_skip,
  input  logic                                         snap_req,
  output logic                                         snap_valid,
  input  logic                                         snap_ack,
  input  logic [7:0]                                   rd_sel,
  output logic [EN_W-1:0]                              rd_data,
  output logic                                         win_valid,
  output logic [$clog2(WINDOW_LEN*NUM_CORES+1)-1:0]    win_act,
  output logic                                         hot,
  output logic                                         sat_flag,
  output logic                                         conflict_flag
);

  localparam int unsigned WACT_W = $clog2(WINDOW_LEN*NUM_CORES+1);
  localparam int unsigned PC_W   = $clog2(NUM_CORES+1);
  localparam int unsigned INC_W  = $clog2(NUM_CORES*E_BASE_PKT+1);
  localparam int unsigned WC_W   = $clog2(WINDOW_LEN);

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cycle enable drops is treated as leaving RUN, so it neither counts nor closes a window.
  logic run, cnt_en;
  assign run    = (state == RUN) && enable;
  assign cnt_en = run && !clear;

  logic [NUM_CORES-1:0] eff_act, eff_skip;
  assign eff_act  = core_active & {NUM_CORES{cnt_en}};
  assign eff_skip = core_skip & ~core_active & {NUM_CORES{cnt_en}};

  logic [PC_W-1:0] n_act, n_skip;
  always_comb begin
    n_act  = '0;
    n_skip = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n_act  = n_act + PC_W'(eff_act[i]);
      n_skip = n_skip + PC_W'(eff_skip[i]);
    end
  end

  logic [INC_W-1:0] pim_inc, base_inc;
  assign pim_inc  = INC_W'(n_act) * INC_W'(E_ACT_PKT) + INC_W'(n_skip) * INC_W'(E_IDLE_PKT);
  assign base_inc = (INC_W'(n_act) + INC_W'(n_skip)) * INC_W'(E_BASE_PKT);

  logic [NUM_CORES-1:0][CNT_W-1:0] act_nxt, skip_nxt;
  logic [NUM_CORES-1:0]            act_sat, skip_sat;
  logic [EN_W-1:0]                 pim_nxt, base_nxt;
  logic [CNT_W-1:0]                cyc_nxt;
  logic                            pim_sat, base_sat, cyc_sat;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    pim_perf_sat_acc #(.W(CNT_W), .INC_W(1)) u_act (
      .clk, .rst_n, .clr(clear), .en(cnt_en), .inc(eff_act[i]),
      .nxt(act_nxt[i]), .sat(act_sat[i]));
    pim_perf_sat_acc #(.W(CNT_W), .INC_W(1)) u_skip (
      .clk, .rst_n, .clr(clear), .en(cnt_en), .inc(eff_skip[i]),
      .nxt(skip_nxt[i]), .sat(skip_sat[i]));
  end

  pim_perf_sat_acc #(.W(EN_W), .INC_W(INC_W)) u_pim (
    .clk, .rst_n, .clr(clear), .en(cnt_en), .inc(pim_inc), .nxt(pim_nxt), .sat(pim_sat));
  pim_perf_sat_acc #(.W(EN_W), .INC_W(INC_W)) u_base (
    .clk, .rst_n, .clr(clear), .en(cnt_en), .inc(base_inc), .nxt(base_nxt), .sat(base_sat));
  pim_perf_sat_acc #(.W(CNT_W), .INC_W(1)) u_cyc (
    .clk, .rst_n, .clr(clear), .en(run), .inc(1'b1), .nxt(cyc_nxt), .sat(cyc_sat));

  logic [WC_W-1:0]   win_cnt, win_cnt_nxt;
  logic [WACT_W-1:0] win_acc, win_acc_nxt, win_act_nxt, win_sum;
  logic              win_valid_nxt, hot_nxt, sat_nxt, conf_nxt;

  assign win_sum = win_acc + WACT_W'(n_act);

  always_comb begin
    win_cnt_nxt   = '0;
    win_acc_nxt   = '0;
    win_valid_nxt = 1'b0;
    win_act_nxt   = win_act;
    hot_nxt       = hot;
    sat_nxt       = sat_flag | (|act_sat) | (|skip_sat) | pim_sat | base_sat | cyc_sat;
    conf_nxt      = conflict_flag | (cnt_en && |(core_active & core_skip));
    if (clear) begin
      win_act_nxt = '0;
      hot_nxt     = 1'b0;
      sat_nxt     = 1'b0;
      conf_nxt    = 1'b0;
    end else if (run) begin
      if (win_cnt == WC_W'(WINDOW_LEN - 1)) begin
        win_valid_nxt = 1'b1;
        win_act_nxt   = win_sum;
        if (32'(win_sum) > HOT_THRESH)       hot_nxt = 1'b1;
        else if (32'(win_sum) < COOL_THRESH) hot_nxt = 1'b0;
      end else begin
        win_cnt_nxt = win_cnt + 1'b1;
        win_acc_nxt = win_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_cnt       <= '0;
      win_acc       <= '0;
      win_act       <= '0;
      win_valid     <= 1'b0;
      hot           <= 1'b0;
      sat_flag      <= 1'b0;
      conflict_flag <= 1'b0;
    end else begin
      win_cnt       <= win_cnt_nxt;
      win_acc       <= win_acc_nxt;
      win_act       <= win_act_nxt;
      win_valid     <= win_valid_nxt;
      hot           <= hot_nxt;
      sat_flag      <= sat_nxt;
      conflict_flag <= conf_nxt;
    end

  // Shadow bank captures next-state values so the snapshot includes the request cycle.
  logic [NUM_CORES-1:0][CNT_W-1:0] sh_act, sh_skip;
  logic [EN_W-1:0]                 sh_pim, sh_base;
  logic [CNT_W-1:0]                sh_cyc;
  logic [2:0]                      sh_flags;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snap_valid <= 1'b0;
      sh_act     <= '0;
      sh_skip    <= '0;
      sh_pim     <= '0;
      sh_base    <= '0;
      sh_cyc     <= '0;
      sh_flags   <= '0;
    end else if (snap_valid && snap_ack) begin
      snap_valid <= 1'b0;
    end else if (snap_req && !snap_valid) begin
      snap_valid <= 1'b1;
      sh_act     <= act_nxt;
      sh_skip    <= skip_nxt;
      sh_pim     <= pim_nxt;
      sh_base    <= base_nxt;
      sh_cyc     <= cyc_nxt;
      sh_flags   <= {sat_nxt, conf_nxt, hot_nxt};
    end

  logic [EN_W-1:0] rd_nxt;
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rd_sel == 8'(i))                         rd_nxt = EN_W'(sh_act[i]);
      if (rd_sel == 8'(idx_skip(NUM_CORES) + i))   rd_nxt = EN_W'(sh_skip[i]);
    end
    if (rd_sel == 8'(idx_pim(NUM_CORES)))   rd_nxt = sh_pim;
    if (rd_sel == 8'(idx_base(NUM_CORES)))  rd_nxt = sh_base;
    if (rd_sel == 8'(idx_cyc(NUM_CORES)))   rd_nxt = EN_W'(sh_cyc);
    if (rd_sel == 8'(idx_flags(NUM_CORES))) rd_nxt = EN_W'(sh_flags);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_nxt;

endmodule
